cache_fifo_replacer: RTL and testbench
======================================

// Module: cache_fifo_replacer
// PURPOSE
//  Per-set FIFO (round-robin) victim selector for the set-associative data cache.
//  Generalises the single-set 4-way selector: parametrised ways/sets, one FIFO pointer per set,
//  invalid-way fill preference, registered victim with valid/ready handshake, flush.
//  Sits between the cache lookup stage (miss detected) and the refill engine.
// PARAMETERS
//  WAYS      4    associativity; power of 2, >=2; WAY_BITS = $clog2(WAYS)
//  SETS      16   number of sets; power of 2; SET_BITS = $clog2(SETS)
//  STAT_W    32   width of statistics counters (only with CACHE_FIFO_STATS_EN)
// PORTS
//  clk            in   1         clock, all state on rising edge
//  rst            in   1         asynchronous, active-high reset
//  req_valid      in   1         miss needs a victim for set req_index
//  req_ready      out  1         replacer accepts a request this cycle
//  req_index      in   SET_BITS  set index of the miss
//  req_line_vld   in   WAYS      valid bits of the addressed set's ways
//  flush          in   1         one-cycle pulse: all set pointers -> 0
//  victim_valid   out  1         victim_way/victim_evict valid
//  victim_ready   in   1         refill engine consumes victim
//  victim_way     out  WAY_BITS  selected way
//  victim_evict   out  1         1 = valid line replaced (writeback check), 0 = fill of empty way
//  stat_fills     out  STAT_W    [CACHE_FIFO_STATS_EN only] fills into invalid ways
//  stat_evicts    out  STAT_W    [CACHE_FIFO_STATS_EN only] evictions of valid lines
// BEHAVIOUR
//  - Reset (async, rst=1): state IDLE, all ptr[s]=0, victim_valid=0, victim_way=0,
//    victim_evict=0, stat counters 0. req_ready=0 while rst asserted.
//  - FSM states IDLE, RESP. req_ready = (state==IDLE) && !flush.
//  - IDLE: on req_valid&&req_ready (accept):
//    * any bit of req_line_vld==0 -> victim_way = lowest-index invalid way, victim_evict=0,
//      ptr[req_index] unchanged;
//    * all ways valid -> victim_way = ptr[req_index], victim_evict=1,
//      ptr[req_index] <= ptr+1, wrapping WAYS-1 -> 0 (WAY_BITS modulo arithmetic).
//    * victim outputs registered; next state RESP. Latency: victim_valid 1 cycle after accept.
//  - RESP: victim_valid=1, outputs held stable until victim_ready=1; on that cycle
//    victim_valid drops next edge, state -> IDLE. Max throughput 1 victim / 2 cycles.
//  - Other sets' pointers never change on a request.
//  - flush in IDLE: all ptr <- 0 next edge, no request accepted that cycle (flush wins).
//  - flush in RESP: pointers cleared; pending victim still delivered unchanged.
//  - req_index/req_line_vld sampled only at accept; ignored otherwise.
//  - rst mid-RESP: pending victim discarded, victim_valid=0 immediately (async).
// CONFIGURATION
//  - Macro CACHE_FIFO_STATS_EN defined: stat_fills/stat_evicts ports present; each increments
//    by 1 at the accept edge per victim_evict value; saturate at all-ones; cleared by rst only.
//  - Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  - Package cache_fifo_pkg: state typedef (IDLE/RESP), default WAYS/SETS localparams,
//    WAY_BITS/SET_BITS helper functions.
//  - Sub-module cache_fifo_first_free: combinational WAYS-bit lowest-zero priority encoder
//    (outputs way index + any_free flag). Pointer array and FSM stay in the top.
// TESTING
//  - Reset: rst pulse -> victim_valid=0, req_ready=1 after release, all ptr 0.
//  - Fill: idx=3, line_vld=4'b1011 -> victim_way=2, evict=0, 1 cycle later; ptr[3] stays 0.
//  - Round-robin wrap: 5 requests idx=5, line_vld=4'b1111 -> ways 0,1,2,3,0, evict=1 each;
//    interleaved idx=6 request -> way 0 (independent pointer).
//  - Backpressure: victim_ready=0 for 4 cycles -> victim_valid/way stable, req_ready=0;
//    new req_valid ignored until handshake completes.
//  - Flush collision: ptr[5]=2, flush+req_valid same cycle -> not accepted; next request
//    idx=5 full -> way 0.
//  - Stats (CACHE_FIFO_STATS_EN): 3 fills + 5 evicts -> stat_fills=3, stat_evicts=5;
//    async rst mid-RESP -> victim_valid=0, counters 0.

Source files
------------

// File: rtl/cache_fifo_pkg.sv
// Shared state type and sizing helpers for the per-set FIFO victim selector.
package cache_fifo_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  localparam int DEF_WAYS = 4;
  localparam int DEF_SETS = 16;

  function automatic int way_bits(input int ways);
    return $clog2(ways);
  endfunction

  // A single-set cache still needs a one-bit index port.
  function automatic int set_bits(input int sets);
    return (sets > 1) ? $clog2(sets) : 1;
  endfunction

endpackage

// File: rtl/cache_fifo_first_free.sv
// Lowest-index invalid way finder: priority encoder over the inverted valid bits.
module cache_fifo_first_free
  import cache_fifo_pkg::*;
#(
  parameter  int WAYS     = DEF_WAYS,
  localparam int WAY_BITS = way_bits(WAYS)
) (
  input  logic [WAYS-1:0]     i_line_vld,
  output logic [WAY_BITS-1:0] o_free_way,
  output logic                o_any_free
);

  // Scan high to low so the lowest invalid way is the last one written.
  always_comb begin
    o_free_way = '0;
    o_any_free = 1'b0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!i_line_vld[i]) begin
        o_free_way = WAY_BITS'(i);
        o_any_free = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_fifo_replacer.sv
// Per-set round-robin victim selector with empty-way fill preference and registered handshake.
// Optional fill/evict statistics counters are built when CACHE_FIFO_STATS_EN is defined.
module cache_fifo_replacer
  import cache_fifo_pkg::*;
#(
  parameter  int WAYS     = DEF_WAYS,
  parameter  int SETS     = DEF_SETS,
`ifdef CACHE_FIFO_STATS_EN
  parameter  int STAT_W   = 32,
`endif
  localparam int WAY_BITS = way_bits(WAYS),
  localparam int SET_BITS = set_bits(SETS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [SET_BITS-1:0] req_index,
  input  logic [WAYS-1:0]     req_line_vld,
  input  logic                flush,
  output logic                victim_valid,
  input  logic                victim_ready,
  output logic [WAY_BITS-1:0] victim_way,
  output logic                victim_evict
`ifdef CACHE_FIFO_STATS_EN
  ,
  output logic [STAT_W-1:0]   stat_fills,
  output logic [STAT_W-1:0]   stat_evicts
`endif
);

  state_t              r_state;
  logic                r_victim_valid;
  logic [WAY_BITS-1:0] r_victim_way;
  logic                r_victim_evict;

  logic [WAY_BITS-1:0] w_ptr [SETS];
  logic [WAY_BITS-1:0] w_ptr_sel;
  logic [WAY_BITS-1:0] w_free_way;
  logic                w_any_free;
  logic                w_accept;

  cache_fifo_first_free #(
    .WAYS (WAYS)
  ) u_first_free (
    .i_line_vld (req_line_vld),
    .o_free_way (w_free_way),
    .o_any_free (w_any_free)
  );

  // Flush takes priority over a request in the same cycle.
  assign req_ready = (r_state == IDLE) && !flush && !rst;
  assign w_accept  = req_valid && req_ready;
  assign w_ptr_sel = w_ptr[req_index];

  genvar gi;
  generate
    for (gi = 0; gi < SETS; gi++) begin : g_ptr
      logic [WAY_BITS-1:0] r_ptr;

      // Only a full-set eviction of this set advances its pointer.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_ptr <= '0;
        end else if (flush) begin
          r_ptr <= '0;
        end else if (w_accept && !w_any_free && (req_index == SET_BITS'(gi))) begin
          r_ptr <= r_ptr + 1'b1;
        end
      end

      assign w_ptr[gi] = r_ptr;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_victim_valid <= 1'b0;
      r_victim_way   <= '0;
      r_victim_evict <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state        <= RESP;
            r_victim_valid <= 1'b1;
            r_victim_way   <= w_any_free ? w_free_way : w_ptr_sel;
            r_victim_evict <= !w_any_free;
          end
        end
        RESP: begin
          if (victim_ready) begin
            r_state        <= IDLE;
            r_victim_valid <= 1'b0;
          end
        end
        default: begin
          r_state        <= IDLE;
          r_victim_valid <= 1'b0;
        end
      endcase
    end
  end

  assign victim_valid = r_victim_valid;
  assign victim_way   = r_victim_way;
  assign victim_evict = r_victim_evict;

`ifdef CACHE_FIFO_STATS_EN
  logic [STAT_W-1:0] r_stat_fills;
  logic [STAT_W-1:0] r_stat_evicts;

  // Counters saturate rather than wrap so long runs never report small totals.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_fills  <= '0;
      r_stat_evicts <= '0;
    end else if (w_accept) begin
      if (w_any_free && (r_stat_fills != '1)) begin
        r_stat_fills <= r_stat_fills + 1'b1;
      end
      if (!w_any_free && (r_stat_evicts != '1)) begin
        r_stat_evicts <= r_stat_evicts + 1'b1;
      end
    end
  end

  assign stat_fills  = r_stat_fills;
  assign stat_evicts = r_stat_evicts;
`endif

endmodule

// File: tb/tb_cache_fifo_replacer.sv
// Directed bench for cache_fifo_replacer; stats checks are built when CACHE_FIFO_STATS_EN is defined.
module tb_cache_fifo_replacer;

  localparam int WAYS = 4;
  localparam int SETS = 16;
  localparam int WB   = 2;
  localparam int SB   = 4;

  logic          clk          = 1'b0;
  logic          rst          = 1'b0;
  logic          req_valid    = 1'b0;
  logic          req_ready;
  logic [SB-1:0] req_index    = '0;
  logic [WAYS-1:0] req_line_vld = '0;
  logic          flush        = 1'b0;
  logic          victim_valid;
  logic          victim_ready = 1'b0;
  logic [WB-1:0] victim_way;
  logic          victim_evict;
`ifdef CACHE_FIFO_STATS_EN
  logic [31:0]   stat_fills;
  logic [31:0]   stat_evicts;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cache_fifo_replacer #(
    .WAYS (WAYS),
    .SETS (SETS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_index    (req_index),
    .req_line_vld (req_line_vld),
    .flush        (flush),
    .victim_valid (victim_valid),
    .victim_ready (victim_ready),
    .victim_way   (victim_way),
    .victim_evict (victim_evict)
`ifdef CACHE_FIFO_STATS_EN
    ,
    .stat_fills   (stat_fills),
    .stat_evicts  (stat_evicts)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: returns {ready_at_request, victim_valid, victim_way, victim_evict}.
  task automatic issue(input logic [SB-1:0] idx, input logic [WAYS-1:0] vld, output logic [4:0] obs);
    logic rdy;
    req_valid    = 1'b1;
    req_index    = idx;
    req_line_vld = vld;
    #1;
    rdy = req_ready;
    step();
    req_valid    = 1'b0;
    req_line_vld = '0;
    obs = {rdy, victim_valid, victim_way, victim_evict};
    victim_ready = 1'b1;
    step();
    victim_ready = 1'b0;
    $display("req idx=%0d vld=%b -> ready=%b valid=%b way=%0d evict=%b",
             idx, vld, obs[4], obs[3], obs[2:1], obs[0]);
  endtask

  task automatic test_reset();
    logic [4:0] obs;
    req_valid = 1'b1; req_index = '0; req_line_vld = '1;
    #1;
    n_cmp++;
    if ({req_ready, victim_valid} !== 2'b00) begin
      n_fail++; $display("FAIL reset_hold: got ready/valid=%b want 00", {req_ready, victim_valid});
    end
    step(); step();
    req_valid = 1'b0;
    rst = 1'b0;
    step();
    n_cmp++;
    if ({req_ready, victim_valid, victim_way, victim_evict} !== 5'b10000) begin
      n_fail++; $display("FAIL reset_release: got %b want 10000",
                         {req_ready, victim_valid, victim_way, victim_evict});
    end
    issue(4'd0, 4'b1111, obs);
    n_cmp++;
    if (obs !== 5'b11001) begin n_fail++; $display("FAIL reset_ptr0: got %b want 11001", obs); end
    issue(4'd15, 4'b1111, obs);
    n_cmp++;
    if (obs !== 5'b11001) begin n_fail++; $display("FAIL reset_ptr15: got %b want 11001", obs); end
  endtask

  task automatic test_fill();
    logic [4:0] obs;
    issue(4'd3, 4'b1011, obs);
    n_cmp++;
    if (obs !== 5'b11100) begin n_fail++; $display("FAIL fill_1011: got %b want 11100", obs); end
    issue(4'd3, 4'b1111, obs);
    n_cmp++;
    if (obs !== 5'b11001) begin n_fail++; $display("FAIL fill_ptr_kept: got %b want 11001", obs); end
    issue(4'd3, 4'b0000, obs);
    n_cmp++;
    if (obs !== 5'b11000) begin n_fail++; $display("FAIL fill_0000: got %b want 11000", obs); end
    issue(4'd3, 4'b0111, obs);
    n_cmp++;
    if (obs !== 5'b11110) begin n_fail++; $display("FAIL fill_0111: got %b want 11110", obs); end
    issue(4'd3, 4'b1111, obs);
    n_cmp++;
    if (obs !== 5'b11011) begin n_fail++; $display("FAIL fill_ptr_next: got %b want 11011", obs); end
  endtask

  task automatic test_round_robin();
    int idx_tab [6] = '{5, 5, 6, 5, 5, 5};
    int way_tab [6] = '{0, 1, 0, 2, 3, 0};
    logic [4:0] obs;
    logic [4:0] exp;
    for (int i = 0; i < 6; i++) begin
      issue(SB'(idx_tab[i]), 4'b1111, obs);
      exp = {1'b1, 1'b1, WB'(way_tab[i]), 1'b1};
      n_cmp++;
      if (obs !== exp) begin n_fail++; $display("FAIL rr_%0d: got %b want %b", i, obs, exp); end
    end
  endtask

  task automatic test_backpressure();
    logic [4:0] obs;
    req_valid = 1'b1; req_index = 4'd7; req_line_vld = 4'b1111;
    step();
    for (int c = 0; c < 4; c++) begin
      n_cmp++;
      if ({req_ready, victim_valid, victim_way, victim_evict} !== 5'b01001) begin
        n_fail++; $display("FAIL bp_hold_%0d: got %b want 01001", c,
                           {req_ready, victim_valid, victim_way, victim_evict});
      end
      step();
    end
    victim_ready = 1'b1;
    step();
    victim_ready = 1'b0;
    req_valid    = 1'b0;
    #1;
    n_cmp++;
    if ({req_ready, victim_valid} !== 2'b10) begin
      n_fail++; $display("FAIL bp_release: got ready/valid=%b want 10", {req_ready, victim_valid});
    end
    issue(4'd7, 4'b1111, obs);
    n_cmp++;
    if (obs !== 5'b11011) begin n_fail++; $display("FAIL bp_no_extra_accept: got %b want 11011", obs); end
  endtask

  task automatic test_flush();
    logic [4:0] obs;
    issue(4'd5, 4'b1111, obs);
    n_cmp++;
    if (obs !== 5'b11011) begin n_fail++; $display("FAIL flush_setup: got %b want 11011", obs); end
    flush = 1'b1; req_valid = 1'b1; req_index = 4'd5; req_line_vld = 4'b1111;
    #1;
    n_cmp++;
    if (req_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b want 0", req_ready); end
    step();
    flush = 1'b0; req_valid = 1'b0;
    n_cmp++;
    if (victim_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_accept: got %b want 0", victim_valid); end
    issue(4'd5, 4'b1111, obs);
    n_cmp++;
    if (obs !== 5'b11001) begin n_fail++; $display("FAIL flush_ptr5: got %b want 11001", obs); end
    issue(4'd6, 4'b1111, obs);
    n_cmp++;
    if (obs !== 5'b11001) begin n_fail++; $display("FAIL flush_ptr6: got %b want 11001", obs); end
    // Flush while a victim is pending.
    issue(4'd8, 4'b1111, obs);
    req_valid = 1'b1; req_index = 4'd8; req_line_vld = 4'b1111;
    step();
    req_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_cmp++;
    if ({victim_valid, victim_way, victim_evict} !== 4'b1011) begin
      n_fail++; $display("FAIL flush_resp_hold: got %b want 1011", {victim_valid, victim_way, victim_evict});
    end
    victim_ready = 1'b1;
    step();
    victim_ready = 1'b0;
    issue(4'd8, 4'b1111, obs);
    n_cmp++;
    if (obs !== 5'b11001) begin n_fail++; $display("FAIL flush_resp_ptr: got %b want 11001", obs); end
  endtask

`ifdef CACHE_FIFO_STATS_EN
  task automatic test_stats();
    logic [4:0] obs;
    rst = 1'b1; #1; rst = 1'b0;
    step();
    for (int i = 0; i < 3; i++) issue(4'd10, 4'b0000, obs);
    for (int i = 0; i < 5; i++) issue(4'd11, 4'b1111, obs);
    n_cmp++;
    if (stat_fills !== 32'd3) begin n_fail++; $display("FAIL stat_fills: got %0d want 3", stat_fills); end
    n_cmp++;
    if (stat_evicts !== 32'd5) begin n_fail++; $display("FAIL stat_evicts: got %0d want 5", stat_evicts); end
  endtask
`endif

  task automatic test_async_reset();
    logic [4:0] obs;
    req_valid = 1'b1; req_index = 4'd9; req_line_vld = 4'b1111;
    step();
    req_valid = 1'b0;
    n_cmp++;
    if (victim_valid !== 1'b1) begin n_fail++; $display("FAIL arst_pending: got %b want 1", victim_valid); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({req_ready, victim_valid} !== 2'b00) begin
      n_fail++; $display("FAIL arst_drop: got ready/valid=%b want 00", {req_ready, victim_valid});
    end
`ifdef CACHE_FIFO_STATS_EN
    n_cmp++;
    if ({stat_fills, stat_evicts} !== 64'd0) begin
      n_fail++; $display("FAIL arst_stats: got %0d/%0d want 0/0", stat_fills, stat_evicts);
    end
`endif
    step();
    rst = 1'b0;
    step();
    issue(4'd9, 4'b1111, obs);
    n_cmp++;
    if (obs !== 5'b11001) begin n_fail++; $display("FAIL arst_ptr9: got %b want 11001", obs); end
  endtask

  initial begin
    #2 rst = 1'b1;
    test_reset();
    test_fill();
    test_round_robin();
    test_backpressure();
    test_flush();
`ifdef CACHE_FIFO_STATS_EN
    test_stats();
`endif
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
